controle_servo_varredura: RTL and testbench

//  Upstream stage of the sonar datapath: sweeps the servo through 8 fixed angles (020..160 deg)

---
 rtl/controle_servo_varredura.sv | 142 ++++++++++++++
 tb/tb_controle_servo_varredura.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_servo_varredura.sv
// Servo sweep controller: steps a servo through 8 angles (20..160 deg) in a triangle
// pattern, drives its PWM and presents the current angle as three ASCII digits.
module controle_servo_varredura #(
    parameter int PWM_PERIOD = 1_000_000,
    parameter int PW_MIN     = 55_556,
    parameter int PW_STEP    = 5_556,
    parameter int T_POS      = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    output logic       pwm,
    output logic [2:0] posicao,
    output logic [6:0] angulo_centena,
    output logic [6:0] angulo_dezena,
    output logic [6:0] angulo_unidade,
    output logic       fim_posicao,
    output logic [3:0] db_estado
);

    localparam int CW = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
    localparam int TW = (T_POS > 1) ? $clog2(T_POS) : 1;

    localparam logic [CW-1:0] CNT_LAST   = CW'(PWM_PERIOD - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(T_POS - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        SINALIZA = 4'd2,
        AVANCA   = 4'd3
    } estado_t;

    estado_t       estado;
    estado_t       proximo;
    logic [TW-1:0] timer;
    logic          descendo;
    logic [CW-1:0] contador;
    logic [CW-1:0] largura;
    logic [CW-1:0] largura_alvo;
    logic [3:0]    dezena_bcd;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    always_comb begin
        proximo     = estado;
        fim_posicao = 1'b0;
        case (estado)
            INICIAL: begin
                if (ligar) proximo = ESPERA;
            end
            ESPERA: begin
                if (!ligar)                   proximo = INICIAL;
                else if (timer == TIMER_LAST) proximo = SINALIZA;
            end
            SINALIZA: begin
                fim_posicao = 1'b1;
                proximo     = ligar ? AVANCA : INICIAL;
            end
            AVANCA: begin
                proximo = ligar ? ESPERA : INICIAL;
            end
            default: proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

    // Dwell timer only runs while the FSM stays in ESPERA; any other path clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (estado == ESPERA && proximo == ESPERA) begin
            timer <= timer + TW'(1);
        end else begin
            timer <= '0;
        end
    end

    // Triangle sweep: direction flips when stepping onto an endpoint.
    always_ff @(posedge clock) begin
        if (reset) begin
            posicao  <= 3'd0;
            descendo <= 1'b0;
        end else if (estado == AVANCA && ligar) begin
            if (!descendo) begin
                posicao <= posicao + 3'd1;
                if (posicao == 3'd6) descendo <= 1'b1;
            end else begin
                posicao <= posicao - 3'd1;
                if (posicao == 3'd1) descendo <= 1'b0;
            end
        end
    end

    assign largura_alvo = CW'(PW_MIN + PW_STEP * int'(posicao));

    // Width is only reloaded at period boundaries so a position change never
    // truncates or stretches the pulse in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= '0;
            largura  <= CW'(PW_MIN);
        end else if (estado == INICIAL) begin
            contador <= '0;
            if (ligar) largura <= largura_alvo;
        end else if (contador == CNT_LAST) begin
            contador <= '0;
            largura  <= largura_alvo;
        end else begin
            contador <= contador + CW'(1);
        end
    end

    assign pwm = (estado != INICIAL) && (contador < largura);

    always_comb begin
        dezena_bcd = 4'd0;
        case (posicao)
            3'd0: dezena_bcd = 4'd2;
            3'd1: dezena_bcd = 4'd4;
            3'd2: dezena_bcd = 4'd6;
            3'd3: dezena_bcd = 4'd8;
            3'd4: dezena_bcd = 4'd0;
            3'd5: dezena_bcd = 4'd2;
            3'd6: dezena_bcd = 4'd4;
            3'd7: dezena_bcd = 4'd6;
            default: dezena_bcd = 4'd0;
        endcase
    end

    assign angulo_centena = {3'b011, 3'b000, posicao[2]};
    assign angulo_dezena  = {3'b011, dezena_bcd};
    assign angulo_unidade = 7'h30;

endmodule

// File: tb/tb_controle_servo_varredura.sv
// Bench for controle_servo_varredura: directed sweep/pause/reset scenarios followed by
// random ligar/reset traffic, all compared every cycle against a dwell/period model.
module tb_controle_servo_varredura;

    localparam int PWM_PERIOD = 100;
    localparam int PW_MIN     = 5;
    localparam int PW_STEP    = 5;
    localparam int T_POS      = 20;

    logic       clock;
    logic       reset;
    logic       ligar;
    logic       pwm;
    logic [2:0] posicao;
    logic [6:0] angulo_centena;
    logic [6:0] angulo_dezena;
    logic [6:0] angulo_unidade;
    logic       fim_posicao;
    logic [3:0] db_estado;

    int checks = 0;
    int errors = 0;

    controle_servo_varredura #(
        .PWM_PERIOD(PWM_PERIOD),
        .PW_MIN    (PW_MIN),
        .PW_STEP   (PW_STEP),
        .T_POS     (T_POS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pwm           (pwm),
        .posicao       (posicao),
        .angulo_centena(angulo_centena),
        .angulo_dezena (angulo_dezena),
        .angulo_unidade(angulo_unidade),
        .fim_posicao   (fim_posicao),
        .db_estado     (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: the sweep is an index into a 14-entry triangle table, a dwell is a
    // phase 0..T_POS+1 (T_POS = signal phase, T_POS+1 = advance phase), PWM is a period phase.
    int seq [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1};
    bit m_run = 1'b0;
    int m_t   = 0;
    int m_idx = 0;
    int m_cnt = 0;
    int m_w   = PW_MIN;

    logic prev_pwm = 1'b0;
    int   run_len  = 0;
    int   rise_w   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_run = 1'b0; m_idx = 0; m_cnt = 0; m_w = PW_MIN; m_t = 0;
        end else if (!m_run) begin
            m_cnt = 0;
            m_t   = 0;
            if (ligar) begin
                m_run = 1'b1;
                m_w   = PW_MIN + seq[m_idx] * PW_STEP;
            end
        end else if (!ligar) begin
            m_run = 1'b0; m_cnt = 0; m_t = 0;
        end else begin
            if (m_cnt == PWM_PERIOD - 1) begin
                m_cnt = 0;
                m_w   = PW_MIN + seq[m_idx] * PW_STEP;
            end else begin
                m_cnt++;
            end
            if (m_t == T_POS + 1) begin
                m_t   = 0;
                m_idx = (m_idx + 1) % 14;
            end else begin
                m_t++;
            end
        end
    endtask

    task automatic check_outputs();
        int ang;
        int st;
        ang = 20 * (seq[m_idx] + 1);
        st  = !m_run ? 0 : (m_t < T_POS) ? 1 : (m_t == T_POS) ? 2 : 3;
        check("db_estado", db_estado, st);
        check("fim_posicao", fim_posicao, (m_run && m_t == T_POS) ? 1 : 0);
        check("posicao", posicao, seq[m_idx]);
        check("pwm", pwm, (m_run && m_cnt < m_w) ? 1 : 0);
        check("angulo_centena", angulo_centena, 32'h30 + ang / 100);
        check("angulo_dezena", angulo_dezena, 32'h30 + (ang / 10) % 10);
        check("angulo_unidade", angulo_unidade, 32'h30 + ang % 10);
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
        check_outputs();
        if (pwm === 1'b1 && prev_pwm !== 1'b1) begin
            run_len = 1;
            rise_w  = m_w;
        end else if (pwm === 1'b1) begin
            run_len++;
        end else if (prev_pwm === 1'b1 && m_run) begin
            check("pwm_pulse_len", run_len, rise_w);
        end
        prev_pwm = pwm;
    endtask

    task automatic wait_fim(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (fim_posicao !== 1'b1 && n < 200);
        if (fim_posicao !== 1'b1) check("wait_fim_timeout", fim_posicao, 1);
    endtask

    initial begin
        int n;
        int highs;
        int exp3 [16] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3};
        int budget;

        // 1: reset, then idle
        reset = 1'b1;
        ligar = 1'b0;
        tick();
        reset = 1'b0;
        check("rst_pwm", pwm, 0);
        check("rst_posicao", posicao, 0);
        check("rst_fim", fim_posicao, 0);
        check("rst_estado", db_estado, 0);
        check("rst_centena", angulo_centena, 7'h30);
        check("rst_dezena", angulo_dezena, 7'h32);
        check("rst_unidade", angulo_unidade, 7'h30);
        highs = 0;
        repeat (300) begin
            tick();
            if (pwm === 1'b1) highs++;
        end
        check("idle_pwm_high", highs, 0);

        // 2: start sweep, first dwell latency and first pulse width
        ligar = 1'b1;
        highs = 0;
        n     = 0;
        do begin
            tick();
            n++;
            if (pwm === 1'b1) highs++;
        end while (fim_posicao !== 1'b1 && n < 200);
        check("first_fim_latency", n, 21);
        tick();
        check("fim_one_cycle", fim_posicao, 0);
        check("pos_before_adv", posicao, 0);
        tick();
        if (pwm === 1'b1) highs++;
        check("first_period_high", highs, 5);
        check("pos_after_adv", posicao, 1);
        check("pos1_centena", angulo_centena, 7'h30);
        check("pos1_dezena", angulo_dezena, 7'h34);
        check("pos1_unidade", angulo_unidade, 7'h30);

        // 3: sixteen dwells of triangle sweep
        for (int d = 0; d < 16; d++) begin
            wait_fim(n);
            check("dwell_spacing", n + 2, 22);
            tick();
            check("fim_one_cycle", fim_posicao, 0);
            tick();
            check("sweep_pos", posicao, exp3[d]);
            if (exp3[d] == 7) begin
                check("pos7_centena", angulo_centena, 7'h31);
                check("pos7_dezena", angulo_dezena, 7'h36);
                check("pos7_unidade", angulo_unidade, 7'h30);
            end
        end

        // 5: pause at position 5 going up, then resume
        budget = 0;
        while (!(m_idx == 5 && db_estado === 4'd1) && budget < 400) begin
            tick();
            budget++;
        end
        check("t5_reached_pos", posicao, 5);
        ligar = 1'b0;
        tick();
        check("pause_estado", db_estado, 0);
        check("pause_pwm", pwm, 0);
        check("pause_pos", posicao, 5);
        repeat ($urandom_range(1, 50)) tick();
        check("pause_pos_held", posicao, 5);
        ligar = 1'b1;
        for (int d = 0; d < 3; d++) begin
            wait_fim(n);
            tick();
            tick();
            check("resume_seq", posicao, (d == 1) ? 7 : 6);
        end

        // 6: reset mid-pulse at position 6 going down
        budget = 0;
        while (!(m_idx == 8 && db_estado === 4'd1) && budget < 400) begin
            tick();
            budget++;
        end
        check("t6_reached_pos", posicao, 6);
        ligar = 1'b0;
        tick();
        ligar = 1'b1;
        tick();
        repeat ($urandom_range(1, 10)) tick();
        check("t6_mid_pulse", pwm, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_pwm", pwm, 0);
        check("t6_rst_pos", posicao, 0);
        check("t6_rst_estado", db_estado, 0);
        check("t6_rst_fim", fim_posicao, 0);
        wait_fim(n);
        check("t6_fim_latency", n, 21);
        tick();
        tick();
        check("t6_seq1", posicao, 1);
        wait_fim(n);
        tick();
        tick();
        check("t6_seq2", posicao, 2);

        // random ligar/reset traffic
        for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            ligar = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(1, 150)) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
